// File: rtl/merge_select_ctrl.sv
// merge_select_ctrl
// Sequencing controller for a one-tuple-per-cycle merger node. It watches the
// heads of two first-word-fall-through FIFOs (A, B), each holding one sorted
// run terminated by a last flag. Each cycle it pops the winning head and
// registers it to the output. When one run ends, it drains the other run and
// then flags the end of the merged run.
// Optional build macro: MERGE_SELECT_DESCENDING_EN
//   defined   -> merge descending-sorted runs (A wins if key(A) >= key(B))
//   undefined -> merge ascending-sorted runs  (A wins if key(B) >= key(A))
// Ties always select A, so equal keys leave in A-before-B order.
module merge_select_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int KEY_WIDTH  = 80,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic                  i_a_last,
  input  logic                  i_a_empty,
  output logic                  o_a_deq,
  input  logic [DATA_WIDTH-1:0] i_b_data,
  input  logic                  i_b_last,
  input  logic                  i_b_empty,
  output logic                  o_b_deq,
  input  logic                  i_stall,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_stall,
  output logic [CNT_WIDTH-1:0]  o_run_count,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_MERGE   = 2'd0,
    ST_DRAIN_A = 2'd1,
    ST_DRAIN_B = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_stall;
  logic [CNT_WIDTH-1:0]  r_run_count;

  logic [KEY_WIDTH-1:0]  w_key_a;
  logic [KEY_WIDTH-1:0]  w_key_b;
  logic                  w_sel_a;
  logic                  w_can_fire;
  logic                  w_a_deq;
  logic                  w_b_deq;
  logic                  w_fire;
  logic                  w_out_last;
  logic [DATA_WIDTH-1:0] w_fire_data;

  assign w_key_a = i_a_data[KEY_WIDTH-1:0];
  assign w_key_b = i_b_data[KEY_WIDTH-1:0];

`ifdef MERGE_SELECT_DESCENDING_EN
  assign w_sel_a = (w_key_a >= w_key_b);
`else
  assign w_sel_a = (w_key_b >= w_key_a);
`endif

  // Reset also blocks popping so the FIFOs are untouched while the block clears.
  assign w_can_fire  = ~i_rst & ~i_stall;
  assign w_fire      = w_a_deq | w_b_deq;
  assign w_fire_data = w_a_deq ? i_a_data : i_b_data;

  // Next-state and dequeue decode; at most one FIFO is popped per cycle.
  always_comb begin
    w_state_next = r_state;
    w_a_deq      = 1'b0;
    w_b_deq      = 1'b0;
    w_out_last   = 1'b0;
    case (r_state)
      ST_MERGE: begin
        // Both heads must be present; a lone head may not be the true minimum.
        if (w_can_fire && !i_a_empty && !i_b_empty) begin
          if (w_sel_a) begin
            w_a_deq = 1'b1;
            if (i_a_last) w_state_next = ST_DRAIN_B;
          end else begin
            w_b_deq = 1'b1;
            if (i_b_last) w_state_next = ST_DRAIN_A;
          end
        end
      end
      ST_DRAIN_A: begin
        if (w_can_fire && !i_a_empty) begin
          w_a_deq = 1'b1;
          if (i_a_last) begin
            w_out_last   = 1'b1;
            w_state_next = ST_MERGE;
          end
        end
      end
      ST_DRAIN_B: begin
        if (w_can_fire && !i_b_empty) begin
          w_b_deq = 1'b1;
          if (i_b_last) begin
            w_out_last   = 1'b1;
            w_state_next = ST_MERGE;
          end
        end
      end
      default: begin
        w_state_next = ST_MERGE;
      end
    endcase
  end

  // Output register, state register, stall delay and completed-run counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_MERGE;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_stall     <= 1'b0;
      r_run_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_fire;
      r_last  <= w_out_last;
      r_stall <= i_stall;
      if (w_fire) r_data <= w_fire_data;
      if (w_out_last) r_run_count <= r_run_count + 1'b1;
    end
  end

  assign o_a_deq     = w_a_deq;
  assign o_b_deq     = w_b_deq;
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_last      = r_last;
  assign o_stall     = r_stall;
  assign o_run_count = r_run_count;
  assign o_state     = r_state;

endmodule

// File: tb/tb_merge_select_ctrl.sv
// Testbench for merge_select_ctrl. The bench plays both FIFOs from queues,
// predicts the merged sequence with a plain merge of the two runs, and checks
// every cycle's outputs and dequeue handshakes against that prediction.
// Build with MERGE_SELECT_DESCENDING_EN to exercise the descending variant.
module tb_merge_select_ctrl;
  localparam int DW = 128;
  localparam int KW = 80;
  localparam int CW = 32;
  localparam int TW = DW - KW;

  typedef logic [KW-1:0] key_t;
  typedef struct packed { logic last; logic [DW-1:0] data; } tup_t;

  logic          clk = 1'b0;
  logic          rst, stall;
  logic [DW-1:0] a_data, b_data, data_o;
  logic          a_last, a_empty, a_deq, b_last, b_empty, b_deq;
  logic          valid_o, last_o, stall_o;
  logic [CW-1:0] run_count;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  merge_select_ctrl #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_data(a_data), .i_a_last(a_last), .i_a_empty(a_empty), .o_a_deq(a_deq),
    .i_b_data(b_data), .i_b_last(b_last), .i_b_empty(b_empty), .o_b_deq(b_deq),
    .i_stall(stall), .o_data(data_o), .o_valid(valid_o), .o_last(last_o),
    .o_stall(stall_o), .o_run_count(run_count), .o_state(state_o)
  );

  tup_t qa[$], qb[$], exp_q[$];
  int   checks = 0, errors = 0;
  // Previous-cycle observations and high-level run progress.
  bit            armed = 0, prev_rst = 0, prev_stall = 0;
  bit            prev_a_deq = 0, prev_b_deq = 0, prev_a_last = 0, prev_b_last = 0;
  logic [DW-1:0] prev_a_data = '0, prev_b_data = '0, last_out = '0;
  bit            a_done = 0, b_done = 0, a_pop = 0, b_pop = 0, log_en = 0;
  int            model_runs = 0, outputs_seen = 0, cyc_count = 0, scn = 0;
  key_t          key_log[$];
  int            cyc_log[$];
  bit            last_log[$];

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic bit sel_a(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MERGE_SELECT_DESCENDING_EN
    return a[KW-1:0] >= b[KW-1:0];
`else
    return b[KW-1:0] >= a[KW-1:0];
`endif
  endfunction

  // Expected merged run: pick by key until one run ends, then the rest of the other.
  task automatic build_exp(input tup_t a[$], input tup_t b[$]);
    int   i, j;
    bit   ad, bd, take_a;
    tup_t t;
    i = 0; j = 0; ad = 0; bd = 0;
    while (!(ad && bd)) begin
      if (!ad && i >= a.size()) break;
      if (!bd && j >= b.size()) break;
      if (ad)      take_a = 0;
      else if (bd) take_a = 1;
      else         take_a = sel_a(a[i].data, b[j].data);
      if (take_a) begin t = a[i]; i++; ad = t.last; end
      else        begin t = b[j]; j++; bd = t.last; end
      t.last = ad && bd;
      exp_q.push_back(t);
    end
  endtask

  task automatic mkrun(input key_t keys[$], input int tagbase, output tup_t r[$]);
    tup_t t;
    r.delete();
    for (int i = 0; i < keys.size(); i++) begin
      t.data = {TW'(tagbase + i), keys[i]};
      t.last = (i == keys.size() - 1);
      r.push_back(t);
    end
  endtask

  task automatic drive();
    a_empty = (qa.size() == 0);
    a_data  = a_empty ? '1 : qa[0].data;
    a_last  = a_empty ? 1'b0 : qa[0].last;
    b_empty = (qb.size() == 0);
    b_data  = b_empty ? '1 : qb[0].data;
    b_last  = b_empty ? 1'b0 : qb[0].last;
  endtask

  // Per-cycle comparison of DUT outputs against the model (called at negedge).
  task automatic compare_outputs();
    tup_t       t;
    logic [1:0] exp_state;
    if (armed) begin
      if (prev_rst) begin
        chk(valid_o == 1'b0, "rst_valid", DW'(valid_o), DW'(0));
        chk(last_o == 1'b0, "rst_last", DW'(last_o), DW'(0));
        chk(data_o == '0, "rst_data", data_o, DW'(0));
        chk(stall_o == 1'b0, "rst_stall", DW'(stall_o), DW'(0));
        chk(run_count == '0, "rst_run_count", DW'(run_count), DW'(0));
        chk(state_o == 2'd0, "rst_state", DW'(state_o), DW'(0));
        a_done = 0; b_done = 0; model_runs = 0; last_out = '0;
      end else begin
        if (prev_a_deq && prev_a_last) a_done = 1;
        if (prev_b_deq && prev_b_last) b_done = 1;
        if (a_done && b_done) begin a_done = 0; b_done = 0; end
        chk(valid_o == (prev_a_deq | prev_b_deq), "latency_valid", DW'(valid_o), DW'(prev_a_deq | prev_b_deq));
        if (prev_a_deq)      chk(data_o == prev_a_data, "latency_data_a", data_o, prev_a_data);
        else if (prev_b_deq) chk(data_o == prev_b_data, "latency_data_b", data_o, prev_b_data);
        if (prev_stall) chk(!valid_o, "stall_gap_valid", DW'(valid_o), DW'(0));
        chk(stall_o == prev_stall, "o_stall_delay", DW'(stall_o), DW'(prev_stall));
        if (valid_o) begin
          if (exp_q.size() == 0) chk(1'b0, "unexpected_output", data_o, DW'(0));
          else begin
            t = exp_q.pop_front();
            chk(data_o == t.data, "out_data", data_o, t.data);
            chk(last_o == t.last, "out_last", DW'(last_o), DW'(t.last));
            last_out = t.data;
            if (t.last) model_runs++;
            outputs_seen++;
            if (log_en) begin
              key_log.push_back(data_o[KW-1:0]);
              cyc_log.push_back(cyc_count);
              last_log.push_back(last_o);
            end
`ifndef MERGE_SELECT_DESCENDING_EN
            if (scn == 4 && data_o[KW-1:0] == '0)
              chk(state_o == 2'd1, "b_first_then_drain_a", DW'(state_o), DW'(1));
`endif
          end
        end else begin
          chk(last_o == 1'b0, "idle_last", DW'(last_o), DW'(0));
          chk(data_o == last_out, "idle_hold_data", data_o, last_out);
        end
        exp_state = a_done ? 2'd2 : (b_done ? 2'd1 : 2'd0);
        chk(state_o == exp_state, "state", DW'(state_o), DW'(exp_state));
        chk(run_count == CW'(model_runs), "run_count", DW'(run_count), DW'(model_runs));
      end
      chk(!(a_deq && b_deq), "deq_exclusive", DW'({a_deq, b_deq}), DW'(0));
      if (a_empty || stall || rst) chk(!a_deq, "a_deq_blocked", DW'(a_deq), DW'(0));
      if (b_empty || stall || rst) chk(!b_deq, "b_deq_blocked", DW'(b_deq), DW'(0));
    end
    if (rst) exp_q.delete();
    armed       = armed | rst;
    prev_rst    = rst;
    prev_stall  = stall;
    prev_a_deq  = a_deq;  prev_b_deq  = b_deq;
    prev_a_last = a_last; prev_b_last = b_last;
    prev_a_data = a_data; prev_b_data = b_data;
  endtask

  // One clock: compare at negedge, then pop and re-drive just after posedge.
  task automatic step();
    @(negedge clk);
    compare_outputs();
    a_pop = a_deq; b_pop = b_deq;
    cyc_count++;
    @(posedge clk);
    #1;
    if (a_pop && qa.size() != 0) void'(qa.pop_front());
    if (b_pop && qb.size() != 0) void'(qb.pop_front());
    drive();
  endtask

  task automatic run_scn(input int id, input tup_t a[$], input tup_t b[$],
                         input int st_lo, input int st_hi, input int b_delay);
    int cyc;
    scn = id;
    build_exp(a, b);
    qa = a;
    qb.delete();
    if (b_delay == 0) qb = b;
    drive();
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 80) begin
      stall = (cyc >= st_lo && cyc <= st_hi);
      if (b_delay != 0 && cyc == b_delay) begin qb = b; drive(); end
      step();
      if (b_delay != 0 && cyc < b_delay)
        chk(!a_pop && !b_pop, "b_empty_no_deq", DW'({a_pop, b_pop}), DW'(0));
      cyc++;
    end
    stall = 1'b0;
    chk(exp_q.size() == 0, "run_complete", DW'(exp_q.size()), DW'(0));
    chk(qa.size() == 0 && qb.size() == 0, "fifos_drained", DW'(qa.size() + qb.size()), DW'(0));
    qa.delete(); qb.delete(); exp_q.delete();
    drive();
  endtask

  tup_t ra[$], rb[$];
  key_t ka[$], kb[$];
  int   base, cyc;
  key_t lit_asc[6]  = '{80'd1, 80'd2, 80'd3, 80'd4, 80'd7, 80'd9};
  key_t lit_desc[4] = '{80'd9, 80'd7, 80'd4, 80'd1};

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive();
    step(); step();
    rst = 1'b0;

    // Basic ascending merge, logged for literal checks.
    ka = '{80'd1, 80'd4, 80'd7}; kb = '{80'd2, 80'd3, 80'd9};
    mkrun(ka, 'hA010, ra); mkrun(kb, 'h0110, rb);
    log_en = 1; run_scn(1, ra, rb, -1, -2, 0); log_en = 0;
`ifndef MERGE_SELECT_DESCENDING_EN
    chk(key_log.size() == 6, "s1_count", DW'(key_log.size()), DW'(6));
    for (int k = 0; k < 6 && k < key_log.size(); k++) begin
      chk(key_log[k] == lit_asc[k], "s1_key", DW'(key_log[k]), DW'(lit_asc[k]));
      chk(last_log[k] == (k == 5), "s1_last", DW'(last_log[k]), DW'(k == 5));
      if (k > 0) chk(cyc_log[k] == cyc_log[k-1] + 1, "s1_consecutive", DW'(cyc_log[k]), DW'(cyc_log[k-1] + 1));
    end
    chk(run_count == 32'd1, "s1_run_count", DW'(run_count), DW'(1));
`endif

    // Equal keys: A before B, last only on the final B tuple.
    ka = '{80'd5, 80'd5}; kb = '{80'd5};
    mkrun(ka, 'hA020, ra); mkrun(kb, 'h0120, rb);
    run_scn(2, ra, rb, -1, -2, 0);

    // Stall during cycles 3..5 of the basic merge.
    ka = '{80'd1, 80'd4, 80'd7}; kb = '{80'd2, 80'd3, 80'd9};
    mkrun(ka, 'hA030, ra); mkrun(kb, 'h0130, rb);
    run_scn(3, ra, rb, 3, 5, 0);

    // B empty for four cycles, then a one-tuple B run.
    ka = '{80'd5, 80'd8}; kb = '{80'd0};
    mkrun(ka, 'hA040, ra); mkrun(kb, 'h0140, rb);
    run_scn(4, ra, rb, -1, -2, 4);

    // Full-width unsigned key comparison (key bit 79 set).
    ka = '{80'h8000_0000_0000_0000_0003}; kb = '{80'd1, 80'd2};
    mkrun(ka, 'hA050, ra); mkrun(kb, 'h0150, rb);
    run_scn(5, ra, rb, -1, -2, 0);

    // Reset after two outputs, then a fresh pair.
    scn = 6;
    ka = '{80'd1, 80'd4, 80'd7}; kb = '{80'd2, 80'd3, 80'd9};
    mkrun(ka, 'hA060, ra); mkrun(kb, 'h0160, rb);
    build_exp(ra, rb);
    qa = ra; qb = rb; drive();
    base = outputs_seen; cyc = 0;
    while (outputs_seen < base + 2 && cyc < 20) begin step(); cyc++; end
    chk(outputs_seen >= base + 2, "pre_reset_outputs", DW'(outputs_seen - base), DW'(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    qa.delete(); qb.delete();
    ka = '{80'd3, 80'd6}; kb = '{80'd4, 80'd5};
    mkrun(ka, 'hA070, ra); mkrun(kb, 'h0170, rb);
    run_scn(7, ra, rb, -1, -2, 0);

`ifdef MERGE_SELECT_DESCENDING_EN
    // Descending merge of A {9,4L}, B {7,1L}.
    key_log.delete(); last_log.delete(); cyc_log.delete();
    ka = '{80'd9, 80'd4}; kb = '{80'd7, 80'd1};
    mkrun(ka, 'hA080, ra); mkrun(kb, 'h0180, rb);
    log_en = 1; run_scn(8, ra, rb, -1, -2, 0); log_en = 0;
    chk(key_log.size() == 4, "desc_count", DW'(key_log.size()), DW'(4));
    for (int k = 0; k < 4 && k < key_log.size(); k++) begin
      chk(key_log[k] == lit_desc[k], "desc_key", DW'(key_log[k]), DW'(lit_desc[k]));
      chk(last_log[k] == (k == 3), "desc_last", DW'(last_log[k]), DW'(k == 3));
    end
`endif

    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
